// File: rtl/mr_cpu_pkg.sv
// Shared CPU datapath constants and types used by the call stack and its neighbours.
package mr_cpu_pkg;

    // Program counter / load address width.
    localparam int unsigned ADDR_W = 16;

    // Default number of return-address entries.
    localparam int unsigned STACK_DEPTH = 8;

    // One program address word.
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/mr_call_stack_if.sv
// Decoder-side request and program-counter load bundle for the return-address stack.
interface mr_call_stack_if
    import mr_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W,
    parameter int unsigned DEPTH = STACK_DEPTH
);

    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic             ena;
    logic [WIDTH-1:0] pc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] addr;
    logic             st;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    // Decoder / test driver side.
    modport master (
        output ena, pc, call, ret, target,
        input  addr, st, level, empty, full, ovf, unf
    );

    // Call stack side.
    modport slave (
        input  ena, pc, call, ret, target,
        output addr, st, level, empty, full, ovf, unf
    );

endinterface

// File: rtl/mr_lifo_mem.sv
// Return-address storage: register array with one write port and an asynchronous read port.
module mr_lifo_mem
    import mr_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W,
    parameter int unsigned DEPTH = STACK_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; only the stack level qualifies them.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the pushed return address on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read so the top entry is usable in the same cycle as a RET.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mr_call_stack.sv
// Return-address stack: executes CALL/RET and drives the program counter load pair.
module mr_call_stack
    import mr_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W,
    parameter int unsigned DEPTH = STACK_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    mr_call_stack_if.slave bus
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             call_eff, ret_eff;
    logic             is_empty, is_full;
    logic             we;
    logic [AW-1:0]    waddr, raddr;
    logic [WIDTH-1:0] wdata, rdata;

    // CALL wins over a simultaneous RET; reset suppresses both.
    assign call_eff = bus.ena & bus.call & ~rst;
    assign ret_eff  = bus.ena & bus.ret & ~bus.call & ~rst;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LW'(DEPTH));

    // Push slot is the current level; top entry sits one below it.
    assign we    = call_eff & ~is_full;
    assign waddr = AW'(level_q);
    assign raddr = AW'(level_q - LW'(1));
    assign wdata = bus.pc + WIDTH'(1);

    mr_lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Same-cycle redirect so the program counter loads on this edge.
    always_comb begin
        bus.st   = 1'b0;
        bus.addr = '0;
        if (call_eff) begin
            bus.st   = 1'b1;
            bus.addr = bus.target;
        end else if (ret_eff && !is_empty) begin
            bus.st   = 1'b1;
            bus.addr = rdata;
        end
    end

    // Next level and sticky error flags.
    always_comb begin
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (call_eff) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                level_d = level_q + LW'(1);
            end
        end else if (ret_eff) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                level_d = level_q - LW'(1);
            end
        end
    end

    // Synchronous reset clears level and flags; entries become don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.level = level_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;

endmodule

// File: tb/tb_mr_call_stack.sv
// Scoreboard bench for mr_call_stack against a queue-based return-stack model.
module tb_mr_call_stack;
    import mr_cpu_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic        st;
        logic [15:0] addr;
        int          level;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mr_call_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mr_call_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t  sb_q[$];
    addr_t model_stack[$];
    logic  m_ovf;
    logic  m_unf;
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: expected response goes to the scoreboard, model advances.
    task automatic cycle(input logic r, input logic e, input logic c, input logic rt,
                         input addr_t p, input addr_t t);
        exp_t x;
        rst        = r;
        bus.ena    = e;
        bus.call   = c;
        bus.ret    = rt;
        bus.pc     = p;
        bus.target = t;
        x.level = model_stack.size();
        x.ovf   = m_ovf;
        x.unf   = m_unf;
        x.st    = 1'b0;
        x.addr  = 16'h0000;
        if (r) begin
            model_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (e && c) begin
            x.st   = 1'b1;
            x.addr = t;
            if (model_stack.size() < DEPTH) model_stack.push_back(p + 16'd1);
            else m_ovf = 1'b1;
        end else if (e && rt) begin
            if (model_stack.size() > 0) begin
                x.st   = 1'b1;
                x.addr = model_stack.pop_back();
            end else begin
                m_unf = 1'b1;
            end
        end
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("st", 32'(bus.st), 32'(x.st));
            chk("addr", 32'(bus.addr), 32'(x.addr));
            chk("level", 32'(bus.level), 32'(x.level));
            chk("empty", 32'(bus.empty), 32'(x.level == 0));
            chk("full", 32'(bus.full), 32'(x.level == DEPTH));
            chk("ovf", 32'(bus.ovf), 32'(x.ovf));
            chk("unf", 32'(bus.unf), 32'(x.unf));
        end
    end

    initial begin
        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.call   = 1'b0;
        bus.ret    = 1'b0;
        bus.pc     = '0;
        bus.target = '0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single call / return.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0200);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000);
        idle();

        // Nested calls unwind in reverse order.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0300);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0500);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0500, 16'h0700);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        idle();

        // Fill, overflow, then drain past empty.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, addr_t'(16'h1000 + i * 16), addr_t'(16'h2000 + i));
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h3000, 16'h0AAA);
        idle();
        repeat (9) cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        idle();

        // Wrap of the return address; unf stays set.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0040);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000);

        // Priority and enable.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h0080);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0080, 16'h0090);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0080, 16'h0090);

        // Reset at level 5 with a call pending.
        repeat (4) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0400, 16'h0500);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0600, 16'h0700);
        idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic  r, e, c, rt;
            addr_t p, t;
            r  = ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 7) != 0);
            c  = ($urandom_range(0, 2) == 0);
            rt = ($urandom_range(0, 1) == 0);
            p  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : addr_t'($urandom);
            t  = addr_t'($urandom);
            cycle(r, e, c, rt, p, t);
        end
        idle();

        @(posedge clk);
        #1;
        chk("drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mr_call_stack.md
Name: mr_call_stack

Overview:
- Return-address stack: the writer side of the program counter's load interface.
- Watches the current PC, executes CALL/RET requests, and drives the ADDR/ST pair that loads the program counter.
- On CALL it pushes the return address (PC+1) and redirects to TARGET. On RET it pops and redirects to the popped address.
- Sits between the instruction decoder and the program counter in the CPU datapath.

Parameters:
- WIDTH, 16, address width; must match PC/ADDR width.
- DEPTH, 8, number of return-address entries (power of 2, at least 2).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- ENA  input  1  qualifies CALL/RET; when 0 the block holds state and ST=0.
- PC  input  WIDTH  current program counter value.
- CALL  input  1  subroutine call request.
- RET  input  1  subroutine return request.
- TARGET  input  WIDTH  call destination address.
- ADDR  output  WIDTH  load address to program counter.
- ST  output  1  load strobe to program counter.
- LEVEL  output  $clog2(DEPTH+1)  number of valid entries.
- EMPTY  output  1  LEVEL==0.
- FULL  output  1  LEVEL==DEPTH.
- OVF  output  1  sticky overflow flag.
- UNF  output  1  sticky underflow flag.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: CLK and RST, RST sampled on the rising edge of CLK.
- Reset values: LEVEL=0, EMPTY=1, FULL=0, OVF=0, UNF=0. ST=0 and ADDR=0 while RST=1, overriding CALL/RET combinationally.
- Stack memory contents are not reset (don't-care); only LEVEL/pointer is cleared.
- Effective requests: call = ENA & CALL & ~RST; ret = ENA & RET & ~CALL & ~RST.
  - CALL has priority; a simultaneous RET is ignored and is not flagged.
- ST/ADDR are combinational in the same cycle as the request, so the program counter loads on the same edge:
  - call: ST=1, ADDR=TARGET.
  - ret with LEVEL>0: ST=1, ADDR=top entry.
  - otherwise (including ret when empty): ST=0, ADDR=0.
- Stack update happens at the rising edge:
  - call with LEVEL<DEPTH: mem[LEVEL] <= PC+1, LEVEL <= LEVEL+1.
  - call with LEVEL==DEPTH: no push, LEVEL unchanged, OVF <= 1; redirect to TARGET still occurs.
  - ret with LEVEL>0: LEVEL <= LEVEL-1.
  - ret with LEVEL==0: LEVEL unchanged, UNF <= 1, ST=0.
- Return address arithmetic: PC+1 modulo 2^WIDTH, so 16'hFFFF pushes 16'h0000.
- Top entry is mem[LEVEL-1]. A push followed by a ret in the next cycle returns the value just pushed (zero-cycle write-to-read visibility via registered storage).
- OVF/UNF are sticky: cleared only by RST.
- Reset mid-sequence discards all entries; the first ret after reset underflows.
- ENA=0: no state change, ST=0, regardless of CALL/RET.

Decomposition:
- Shared package mr_cpu_pkg:
  - ADDR_W=16 constant.
  - Stack-depth default constant.
  - Typedef for address word.
- One sub-module: mr_lifo_mem.
  - DEPTH x WIDTH register array.
  - Write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- The top block holds LEVEL, flags and the ST/ADDR mux.

Test Plan:
- Reset, then PC=16'h0010, CALL=1, TARGET=16'h0200, ENA=1 for one cycle -> same cycle ST=1, ADDR=16'h0200; next cycle LEVEL=1, EMPTY=0.
- Then RET=1 -> ST=1, ADDR=16'h0011; next cycle LEVEL=0, EMPTY=1.
- Nested: 3 calls at PC=16'h0100/16'h0300/16'h0500, then 3 rets -> ADDRs 16'h0501, 16'h0301, 16'h0101 in order; LEVEL returns to 0.
- Fill 8 calls, then a 9th call with TARGET=16'h0AAA:
  - FULL=1 after the 8th call.
  - 9th call gives ST=1, ADDR=16'h0AAA, OVF=1, LEVEL stays 8.
  - Next ret returns the 8th pushed address.
- Wrap and underflow:
  - RET when empty -> ST=0, UNF=1 sticky across later valid calls.
  - CALL at PC=16'hFFFF then RET -> ADDR=16'h0000.
- Priority, enable and reset:
  - CALL=RET=1 -> treated as call only.
  - ENA=0 with CALL=1 -> ST=0, LEVEL unchanged.
  - RST=1 with LEVEL=5 and CALL=1 -> ST=0; next cycle LEVEL=0, OVF=UNF=0.
